// File: rtl/glb_rd_responder.sv
// GLB read responder: turns crossbar read indices into SRAM reads at a
// configured base, re-times the fixed-latency SRAM data into an in-order
// FWFT output FIFO, and uses a credit counter so that every accepted read
// already owns a FIFO slot when its data returns.
module glb_rd_responder #(
  parameter int IDX_WIDTH       = 10,
  parameter int ACT_WIDTH       = 8,
  parameter int POOL_COMP_CORE  = 64,
  parameter int SRAM_ADDR_WIDTH = 12,
  parameter int RD_LATENCY      = 2,
  parameter int OUT_DEPTH       = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                MIFGLB_Rst,
  input  logic [SRAM_ADDR_WIDTH-1:0]          CCUGLB_BaseAddr,
  input  logic                                MIFGLB_AddrVld,
  input  logic [IDX_WIDTH-1:0]                MIFGLB_Addr,
  output logic                                GLBMIF_AddrRdy,
  output logic                                GLBSRAM_Rd,
  output logic [SRAM_ADDR_WIDTH-1:0]          GLBSRAM_Addr,
  input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] SRAMGLB_Dat,
  output logic [ACT_WIDTH*POOL_COMP_CORE-1:0] GLBMIF_Ofm,
  output logic                                GLBMIF_OfmVld,
  input  logic                                MIFGLB_OfmRdy,
  output logic                                GLBMIF_Idle
);

  localparam int DW = ACT_WIDTH * POOL_COMP_CORE;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(OUT_DEPTH - 1);

  logic                  run;
  logic [CW-1:0]         count;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [DW-1:0]         mem [OUT_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_cnt;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // Request side: ready depends only on registered credit state and the clear.
  assign GLBMIF_AddrRdy = run & (count < DEPTH_C) & ~MIFGLB_Rst;
  assign accept         = MIFGLB_AddrVld & GLBMIF_AddrRdy;
  assign GLBSRAM_Rd     = accept;
  assign GLBSRAM_Addr   = CCUGLB_BaseAddr + SRAM_ADDR_WIDTH'(MIFGLB_Addr);

  // Return side: the last pipeline stage marks the cycle SRAM data is valid.
  assign push          = pipe_vld[RD_LATENCY-1];
  assign GLBMIF_OfmVld = (fifo_cnt != '0);
  assign pop           = GLBMIF_OfmVld & MIFGLB_OfmRdy;
  assign GLBMIF_Ofm    = mem[rd_ptr];
  assign GLBMIF_Idle   = (count == '0);

  // Hold ready low through reset; it opens on the first edge after release.
  // NOTE: a registered enable keeps ready off the async reset net; gating
  // with rst_n directly would put the reset into the handshake path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Credits: reads in flight plus rows waiting in the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 count <= '0;
    else if (MIFGLB_Rst)        count <= '0;
    else if (accept && !pop)    count <= count + 1'b1;
    else if (pop && !accept)    count <= count - 1'b1;
  end

  // Valid-bit shift register tracking the SRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
    end else if (MIFGLB_Rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      for (int i = 1; i < RD_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // FIFO pointers and occupancy; a clear flushes everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (MIFGLB_Rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Row storage written with returning SRAM data.
  // NOTE: storage has no reset; stale rows are never visible because
  // OfmVld comes only from the reset occupancy count.
  always_ff @(posedge clk) begin
    if (push && !MIFGLB_Rst) mem[wr_ptr] <= SRAMGLB_Dat;
  end

endmodule
